// File: rtl/i2d_if_pfq_pkg.sv
// Shared types and constants for the i2d instruction prefetch unit.
// The HALT state is only present when I2D_IF_BUSERR_EN is defined.
package i2d_if_pfq_pkg;

    // Opcode byte placed in the top byte of the instruction word to form a NOP.
    localparam logic [7:0] I2D_INS_NOP = 8'h13;

`ifdef I2D_IF_BUSERR_EN
    typedef enum logic [1:0] {StIdle, StReq, StDrain, StHalt} if_state_e;
`else
    typedef enum logic [1:0] {StIdle, StReq, StDrain} if_state_e;
`endif

    // Queue entries are packed as {fault, pc, ins}; the fault flag is the MSB.
    function automatic int unsigned fault_bit(int unsigned aw, int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/i2d_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module i2d_sync_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign do_push = push_i & ~full & ~flush_i;
    assign do_pop  = pop_i & (cnt_q != '0) & ~flush_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/i2d_if_pfq.sv
// Prefetching instruction fetch unit: Wishbone classic read master feeding a DEPTH-entry queue.
// Define I2D_IF_BUSERR_EN to turn err_i into a faulting queue entry plus HALT instead of a retry.
module i2d_if_pfq
    import i2d_if_pfq_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cyc_o,
    output logic          stb_o,
    output logic [AW-1:0] adr_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i,
    input  logic          rty_i,
    input  logic          err_i,
    input  logic          if_en,
    input  logic          set_pc,
    input  logic [AW-1:0] new_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [DW-1:0] if_ins,
    output logic [AW-1:0] if_pc,
    output logic          if_busy,
    output logic          if_fault
);

    localparam int unsigned   BW      = DW / 8;
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
`ifdef I2D_IF_BUSERR_EN
    localparam int unsigned   EW      = fault_bit(AW, DW) + 1;
`else
    localparam int unsigned   EW      = AW + DW;
`endif
    localparam logic [AW-1:0] PcStep  = AW'(BW);
    localparam logic [AW-1:0] PcMask  = ~(AW'(BW - 1));
    localparam logic [DW-1:0] NopWord = DW'(I2D_INS_NOP) << (DW - 8);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

    if_state_e     st_q, st_d;
    logic [AW-1:0] pc_q, pc_d, adr_q, adr_d, redir_pc;
    logic          stb_q, stb_d;
    logic [CW-1:0] count;
    logic [CW:0]   cnt_after;
    logic [EW-1:0] wdata, rdata;
    logic          push, pop, ack_t, err_t, rty_t, term, credit_now, credit_after;

    // Terminations only count while a strobe is out; priority ack > err > rty.
    assign ack_t    = stb_q & ack_i;
    assign err_t    = stb_q & ~ack_i & err_i;
    assign rty_t    = stb_q & ~ack_i & ~err_i & rty_i;
    assign term     = ack_t | err_t | rty_t;
    assign redir_pc = new_pc & PcMask;

    assign if_valid = (count != '0);
    assign pop      = if_valid & if_ready & ~set_pc;

`ifdef I2D_IF_BUSERR_EN
    assign push  = (st_q == StReq) & (ack_t | err_t) & ~set_pc;
    assign wdata = {err_t, adr_q, (err_t ? NopWord : dat_i)};
`else
    assign push  = (st_q == StReq) & ack_t & ~set_pc;
    assign wdata = {adr_q, dat_i};
`endif

    // Outstanding is zero in IDLE; after an ack the slot is reused, so use post-push occupancy.
    assign cnt_after    = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
    assign credit_now   = (count < DepthC);
    assign credit_after = (cnt_after < {1'b0, DepthC});

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        adr_d = adr_q;
        stb_d = stb_q;
        unique case (st_q)
            StIdle: begin
                if (set_pc) begin
                    pc_d = redir_pc;
                    if (if_en) begin
                        st_d  = StReq;
                        stb_d = 1'b1;
                        adr_d = redir_pc;
                    end
                end else if (if_en && credit_now) begin
                    st_d  = StReq;
                    stb_d = 1'b1;
                    adr_d = pc_q;
                end
            end
            StReq: begin
                if (set_pc) begin
                    pc_d = redir_pc;
                    if (!term) begin
                        st_d = StDrain;
                    end else if (if_en) begin
                        adr_d = redir_pc;
                    end else begin
                        st_d  = StIdle;
                        stb_d = 1'b0;
                    end
                end else if (ack_t) begin
                    pc_d = pc_q + PcStep;
                    if (if_en && credit_after) begin
                        adr_d = pc_q + PcStep;
                    end else begin
                        st_d  = StIdle;
                        stb_d = 1'b0;
                    end
`ifdef I2D_IF_BUSERR_EN
                end else if (err_t) begin
                    st_d  = StHalt;
                    stb_d = 1'b0;
`endif
                end
            end
            StDrain: begin
                if (set_pc) pc_d = redir_pc;
                if (term) begin
                    if (if_en) begin
                        st_d  = StReq;
                        adr_d = set_pc ? redir_pc : pc_q;
                    end else begin
                        st_d  = StIdle;
                        stb_d = 1'b0;
                    end
                end
            end
`ifdef I2D_IF_BUSERR_EN
            StHalt: begin
                if (set_pc) begin
                    pc_d = redir_pc;
                    if (if_en) begin
                        st_d  = StReq;
                        stb_d = 1'b1;
                        adr_d = redir_pc;
                    end else begin
                        st_d = StIdle;
                    end
                end
            end
`endif
            default: begin
                st_d  = StIdle;
                stb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q  <= StIdle;
            pc_q  <= RESET_PC;
            adr_q <= '0;
            stb_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            adr_q <= adr_d;
            stb_q <= stb_d;
        end
    end

    i2d_sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (set_pc),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count)
    );

    assign cyc_o   = stb_q;
    assign stb_o   = stb_q;
    assign adr_o   = adr_q;
    assign if_ins  = if_valid ? rdata[DW-1:0] : NopWord;
    assign if_pc   = if_valid ? rdata[AW+DW-1:DW] : '0;
    assign if_busy = ~if_valid | (st_q == StDrain);
`ifdef I2D_IF_BUSERR_EN
    assign if_fault = if_valid & rdata[EW-1];
`else
    assign if_fault = 1'b0;
`endif

endmodule

// File: tb/tb_i2d_if_pfq.sv
// Self-checking bench for i2d_if_pfq: directed scenarios plus a randomized run against
// a stream-level model (expected decode PC sequence and instruction memory contents).
module tb_i2d_if_pfq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc_o, stb_o;
    logic [31:0] adr_o;
    logic [31:0] dat_i;
    logic        ack_i, rty_i, err_i;
    logic        if_en, set_pc;
    logic [31:0] new_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_ins, if_pc;
    logic        if_busy, if_fault;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] Nop = 32'h1300_0000;
`ifdef I2D_IF_BUSERR_EN
    localparam bit ErrRetry = 1'b0;
`else
    localparam bit ErrRetry = 1'b1;
`endif

    i2d_if_pfq #(
        .AW       (32),
        .DW       (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .adr_o    (adr_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .rty_i    (rty_i),
        .err_i    (err_i),
        .if_en    (if_en),
        .set_pc   (set_pc),
        .new_pc   (new_pc),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_ins   (if_ins),
        .if_pc    (if_pc),
        .if_busy  (if_busy),
        .if_fault (if_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Slave response for the coming edge; terminations only while a strobe is out.
    task automatic bus_resp(input logic a, input logic r, input logic e);
        ack_i = a & stb_o;
        rty_i = r & stb_o;
        err_i = e & stb_o;
        dat_i = mem_word(adr_o);
    endtask

    task automatic do_reset();
        rst = 1'b0; if_en = 1'b0; if_ready = 1'b0; set_pc = 1'b0; new_pc = '0;
        ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0; dat_i = '0;
        tick();
        check_eq("rst_cyc", cyc_o, 0);
        check_eq("rst_stb", stb_o, 0);
        check_eq("rst_adr", adr_o, 0);
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_pc", if_pc, 0);
        check_eq("rst_fault", if_fault, 0);
        check_eq("rst_busy", if_busy, 1);
        check_eq("rst_ins", if_ins, Nop);
        tick();
        rst = 1'b1;
    endtask

    int acks, n8, r8, pops, r;
    logic [31:0] exp_pc, prev_adr;
    logic prev_stb, prev_term, prev_set, seen;

    initial begin
        // Streaming: one word per cycle after startup.
        do_reset();
        if_en = 1'b1; if_ready = 1'b1;
        tick();
        check_eq("st_stb", stb_o, 1);
        check_eq("st_adr0", adr_o, 0);
        check_eq("st_valid0", if_valid, 0);
        bus_resp(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("st_valid", if_valid, 1);
            check_eq("st_pc", if_pc, 32'(4 * k));
            check_eq("st_ins", if_ins, mem_word(32'(4 * k)));
            check_eq("st_adr", adr_o, 32'(4 * k + 4));
            bus_resp(1, 0, 0);
        end

        // Backpressure: queue fills to DEPTH, then one pop buys one access.
        do_reset();
        if_en = 1'b1;
        acks = 0;
        repeat (12) begin
            tick();
            if (stb_o) acks++;
            bus_resp(1, 0, 0);
        end
        check_eq("bp_acks", acks, 4);
        check_eq("bp_stb_low", stb_o, 0);
        check_eq("bp_head", if_pc, 0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        check_eq("bp_head_after_pop", if_pc, 4);
        acks = 0;
        repeat (6) begin
            tick();
            if (stb_o) acks++;
            bus_resp(1, 0, 0);
        end
        check_eq("bp_refill", acks, 1);

        // Retry: 0x8 retried twice, then acked; single entry.
        do_reset();
        if_en = 1'b1;
        n8 = 0; r8 = 0;
        repeat (12) begin
            tick();
            if (stb_o && adr_o == 32'h8) begin
                n8++;
                if (r8 < 2) begin r8++; bus_resp(0, 1, 0); end
                else bus_resp(1, 0, 0);
            end else bus_resp(1, 0, 0);
        end
        check_eq("rty_hold_cycles", n8, 3);
        if_en = 1'b0; if_ready = 1'b1; bus_resp(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check_eq("rty_valid", if_valid, 1);
            check_eq("rty_pc", if_pc, 32'(4 * k));
            tick();
        end
        check_eq("rty_empty", if_valid, 0);

        // Redirect while strobe pending: drain, discard, restart at aligned target.
        do_reset();
        if_en = 1'b1;
        tick(); bus_resp(1, 0, 0);
        tick(); bus_resp(1, 0, 0);
        tick();
        check_eq("rd_adr8", adr_o, 32'h8);
        set_pc = 1'b1; new_pc = 32'h103; bus_resp(0, 0, 0);
        tick();
        set_pc = 1'b0;
        check_eq("rd_flush", if_valid, 0);
        check_eq("rd_drain_adr", adr_o, 32'h8);
        check_eq("rd_busy", if_busy, 1);
        bus_resp(0, 0, 0);
        tick();
        check_eq("rd_drain_stb", stb_o, 1);
        bus_resp(1, 0, 0);
        tick();
        check_eq("rd_new_adr", adr_o, 32'h100);
        check_eq("rd_new_stb", stb_o, 1);
        check_eq("rd_still_empty", if_valid, 0);
        bus_resp(1, 0, 0);
        tick();
        check_eq("rd_first_pc", if_pc, 32'h100);
        check_eq("rd_first_ins", if_ins, mem_word(32'h100));

        // Redirect coincident with ack and pop.
        do_reset();
        if_en = 1'b1; if_ready = 1'b1;
        tick(); bus_resp(1, 0, 0);
        repeat (3) begin tick(); bus_resp(1, 0, 0); end
        check_eq("co_valid_before", if_valid, 1);
        set_pc = 1'b1; new_pc = 32'h200;
        tick();
        set_pc = 1'b0;
        check_eq("co_flush", if_valid, 0);
        check_eq("co_adr", adr_o, 32'h200);
        bus_resp(1, 0, 0);
        tick();
        check_eq("co_pc", if_pc, 32'h200);
        check_eq("co_ins", if_ins, mem_word(32'h200));

        // Bus error at 0x20.
        do_reset();
        set_pc = 1'b1; new_pc = 32'h20;
        tick();
        set_pc = 1'b0; if_en = 1'b1;
        tick();
        check_eq("err_adr", adr_o, 32'h20);
        check_eq("err_stb", stb_o, 1);
        bus_resp(0, 0, 1);
        tick();
        bus_resp(0, 0, 0);
        if (ErrRetry) begin
            check_eq("err_reissue_stb", stb_o, 1);
            check_eq("err_reissue_adr", adr_o, 32'h20);
            check_eq("err_no_entry", if_valid, 0);
            bus_resp(1, 0, 0);
            tick();
            check_eq("err_retry_pc", if_pc, 32'h20);
            check_eq("err_retry_fault", if_fault, 0);
        end else begin
            check_eq("err_valid", if_valid, 1);
            check_eq("err_pc", if_pc, 32'h20);
            check_eq("err_fault", if_fault, 1);
            check_eq("err_ins", if_ins, Nop);
            seen = 1'b0;
            repeat (5) begin tick(); if (stb_o) seen = 1'b1; end
            check_eq("err_halt_quiet", seen, 0);
            set_pc = 1'b1; new_pc = 32'h40;
            tick();
            set_pc = 1'b0;
            check_eq("err_resume_flush", if_fault, 0);
            seen = stb_o;
            for (int i = 0; i < 3 && !seen; i++) begin tick(); seen = stb_o; end
            check_eq("err_resume_stb", seen, 1);
            check_eq("err_resume_adr", adr_o, 32'h40);
        end

        // Randomized run against the stream model.
        do_reset();
        exp_pc = 32'h0; pops = 0;
        prev_stb = 1'b0; prev_term = 1'b0; prev_set = 1'b0; prev_adr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_set) check_eq("rnd_flush", if_valid, 0);
            if (prev_stb && stb_o && !prev_term) check_eq("rnd_adr_hold", adr_o, prev_adr);
            r = $urandom_range(0, 9);
            set_pc = ($urandom_range(0, 24) == 0);
            new_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            if_ready = ($urandom_range(0, 3) != 0);
            if_en = ($urandom_range(0, 7) != 0);
            bus_resp(r < 6, r == 6, ErrRetry && r == 7);
            if (if_valid && if_ready && !set_pc) begin
                check_eq("rnd_pc", if_pc, exp_pc);
                check_eq("rnd_ins", if_ins, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (set_pc) exp_pc = new_pc & ~32'h3;
            prev_stb = stb_o; prev_adr = adr_o; prev_set = set_pc;
            prev_term = ack_i | rty_i | err_i;
            tick();
        end
        check_eq("rnd_progress", pops > 200, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
